fifo_uart_tx: RTL

Serial drain stage placed directly downstream of the 16x8 byte FIFO. It pops one byte at a time through the FIFO's read-enable/empty handshake and shifts each byte out as an asynchronous serial frame: one start bit, eight data bits LSB first, optional parity, one stop bit. It is the consumer that turns buffered bytes into a line-level serial stream.

---
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Serial drain stage for the byte FIFO: pops one byte per frame and shifts it out as 8N1.
// Define FIFO_UART_TX_PARITY_EN to add an even parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StStart,
    StData,
`ifdef FIFO_UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d always carries the level for the next bit, so the line stays a pure register output.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    fifo_re  = 1'b0;
    bit_end  = (cnt_q == CntMax);

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        fifo_re = rst & tx_en & ~fifo_empty;
        if (tx_en && !fifo_empty) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d  = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d     = 1'b0;
        cnt_d    = '0;
        state_d  = StStart;
      end
      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxMax) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle);

endmodule
